// File: rtl/nubus_pkg.sv
// nubus_pkg: shared FSM states, ACK status codes and address-space constants for the NuBus slave
package nubus_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACK} state_e;
  localparam logic [1:0] ST_COMPLETE = 2'b11;
  localparam logic [1:0] ST_ERROR    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT  = 2'b01;
  localparam logic [1:0] ST_TRYAGAIN = 2'b00;
  localparam logic [3:0] STD_SPACE   = 4'hF;
endpackage

// File: rtl/nubus_slot_decode.sv
// nubus_slot_decode: address/slot hit decode; superslot space decoded only with NUBUS_SUPERSLOT_EN
module nubus_slot_decode
  import nubus_pkg::*;
(
  input  logic [7:0] addr_hi_i,
  input  logic [3:0] slot_i,
  output logic       hit_o,
  output logic       myslot_o
);
  logic std_hit;
  logic super_hit;
  assign std_hit = (addr_hi_i[7:4] == STD_SPACE) && (addr_hi_i[3:0] == slot_i);
`ifdef NUBUS_SUPERSLOT_EN
  assign super_hit = (addr_hi_i[7:4] == slot_i) && (slot_i != 4'h0) && (slot_i != 4'hF);
`else
  assign super_hit = 1'b0;
`endif
  assign hit_o    = std_hit | super_hit;
  assign myslot_o = std_hit;
endmodule

// File: rtl/nubus_slave_fsm.sv
// nubus_slave_fsm: NuBus slave transaction controller (START decode, local handshake, ACK with status); optional NUBUS_SUPERSLOT_EN
module nubus_slave_fsm
  import nubus_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int MIN_WAIT  = 0,
  parameter int TIMEOUT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_tm0n,
  input  logic        nub_tm1n,
  input  logic [31:0] nub_adn,
  output logic        nub_ackn_o,
  output logic        nub_tm0n_o,
  output logic        nub_tm1n_o,
  output logic        nub_oe,
  output logic        slave,
  output logic        tm1ln,
  output logic        myslot,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_error
);
  localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WAIT_MIN = TIMEOUT_W'(MIN_WAIT + 1);
  state_e state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [1:0] st_q, st_d, tm_q, tm_d;
  logic ackn_q, ackn_d, oe_q, oe_d, slave_q, slave_d, tm1ln_q, tm1ln_d;
  logic myslot_q, myslot_d, valid_q, valid_d, write_q, write_d;
  logic [31:0] addr_q, addr_d, addr;
  logic hit, hit_my;
  logic unused_tm0n;
  assign unused_tm0n = nub_tm0n;
  assign addr = ~nub_adn;
  nubus_slot_decode u_dec (
    .addr_hi_i (addr[31:24]),
    .slot_i    (~nub_idn),
    .hit_o     (hit),
    .myslot_o  (hit_my)
  );
  // next state and next registered outputs; ACK/TM drives default to released
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    tm_d     = 2'b11;
    ackn_d   = 1'b1;
    oe_d     = 1'b0;
    slave_d  = slave_q;
    tm1ln_d  = tm1ln_q;
    myslot_d = myslot_q;
    valid_d  = valid_q;
    write_d  = write_q;
    addr_d   = addr_q;
    unique case (state_q)
      IDLE: if (!nub_startn && hit) begin
        addr_d   = addr;
        write_d  = ~nub_tm1n;
        tm1ln_d  = nub_tm1n;
        myslot_d = hit_my;
        cnt_d    = '0;
        slave_d  = 1'b1;
        valid_d  = 1'b1;
        state_d  = REQ;
      end
      REQ: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (mem_ready) begin
          valid_d = 1'b0;
          st_d    = mem_error ? ST_ERROR : ST_COMPLETE;
          state_d = WAIT;
        end else if (cnt_q == TO_LAST) begin
          valid_d = 1'b0;
          st_d    = ST_TIMEOUT;
          tm_d    = ST_TIMEOUT;
          ackn_d  = 1'b0;
          oe_d    = 1'b1;
          state_d = ACK;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        if (cnt_q >= WAIT_MIN) begin
          tm_d    = st_q;
          ackn_d  = 1'b0;
          oe_d    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        slave_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      st_q     <= ST_COMPLETE;
      tm_q     <= 2'b11;
      ackn_q   <= 1'b1;
      oe_q     <= 1'b0;
      slave_q  <= 1'b0;
      tm1ln_q  <= 1'b0;
      myslot_q <= 1'b0;
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      tm_q     <= tm_d;
      ackn_q   <= ackn_d;
      oe_q     <= oe_d;
      slave_q  <= slave_d;
      tm1ln_q  <= tm1ln_d;
      myslot_q <= myslot_d;
      valid_q  <= valid_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
    end
  end
  assign nub_ackn_o = ackn_q;
  assign nub_tm1n_o = tm_q[1];
  assign nub_tm0n_o = tm_q[0];
  assign nub_oe     = oe_q;
  assign slave      = slave_q;
  assign tm1ln      = tm1ln_q;
  assign myslot     = myslot_q;
  assign mem_valid  = valid_q;
  assign mem_write  = write_q;
  assign mem_addr   = addr_q;
endmodule

// File: tb/tb_nubus_slave_fsm.sv
// tb_nubus_slave_fsm: directed self-checking bench for nubus_slave_fsm (TIMEOUT=8, MIN_WAIT=0)
module tb_nubus_slave_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] nub_idn = ~4'h9;
  logic nub_startn = 1'b1, nub_tm0n = 1'b1, nub_tm1n = 1'b1;
  logic [31:0] nub_adn = '1;
  logic nub_ackn_o, nub_tm0n_o, nub_tm1n_o, nub_oe;
  logic slave, tm1ln, myslot, mem_valid, mem_write;
  logic [31:0] mem_addr;
  logic mem_ready = 1'b0, mem_error = 1'b0;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  nubus_slave_fsm #(.TIMEOUT(8), .MIN_WAIT(0), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset), .nub_idn(nub_idn), .nub_startn(nub_startn),
    .nub_tm0n(nub_tm0n), .nub_tm1n(nub_tm1n), .nub_adn(nub_adn),
    .nub_ackn_o(nub_ackn_o), .nub_tm0n_o(nub_tm0n_o), .nub_tm1n_o(nub_tm1n_o),
    .nub_oe(nub_oe), .slave(slave), .tm1ln(tm1ln), .myslot(myslot),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_error(mem_error)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic start(input logic [31:0] a, input logic tm1);
    nub_startn = 1'b0;
    nub_adn = ~a;
    nub_tm1n = tm1;
    tick();
    nub_startn = 1'b1;
    nub_adn = '1;
    nub_tm1n = 1'b1;
  endtask
  initial begin
    tick();
    tick();
    check("rst_ackn", {31'd0, nub_ackn_o}, 32'd1);
    check("rst_tm", {30'd0, nub_tm1n_o, nub_tm0n_o}, 32'd3);
    check("rst_oe", {31'd0, nub_oe}, 32'd0);
    check("rst_flags", {26'd0, slave, tm1ln, myslot, mem_valid, mem_write, 1'b0}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;
    tick();
    start(32'hF900_0010, 1'b1);
    check("rd_flags", {27'd0, slave, tm1ln, myslot, mem_valid, mem_write}, 32'b11110);
    check("rd_addr", mem_addr, 32'hF900_0010);
    check("rd_ack_e0", {31'd0, nub_ackn_o}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("rd_valid_drop", {31'd0, mem_valid}, 32'd0);
    check("rd_ack_e1", {31'd0, nub_ackn_o}, 32'd1);
    tick();
    check("rd_ack", {29'd0, nub_oe, nub_ackn_o, 1'b0}, 32'b100);
    check("rd_status", {30'd0, nub_tm1n_o, nub_tm0n_o}, 32'b11);
    tick();
    check("rd_end", {28'd0, nub_oe, nub_ackn_o, slave, 1'b0}, 32'b0100);
    check("rd_hold", {30'd0, tm1ln, myslot}, 32'b11);
    start(32'hF300_0000, 1'b1);
    check("miss_flags", {30'd0, slave, mem_valid}, 32'd0);
    check("miss_addr", mem_addr, 32'hF900_0010);
    tick();
    check("miss_valid", {31'd0, mem_valid}, 32'd0);
    start(32'hF9AB_CDE0, 1'b0);
    check("wr_flags", {28'd0, slave, tm1ln, mem_valid, mem_write}, 32'b1011);
    tick();
    tick();
    check("wr_valid_held", {31'd0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    mem_error = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_error = 1'b0;
    check("wr_valid_drop", {30'd0, mem_valid, nub_ackn_o}, 32'b01);
    tick();
    check("wr_ack", {29'd0, nub_oe, nub_ackn_o, 1'b0}, 32'b100);
    check("wr_status", {30'd0, nub_tm1n_o, nub_tm0n_o}, 32'b10);
    tick();
    check("wr_end", {30'd0, nub_ackn_o, slave}, 32'b10);
    start(32'hF900_0100, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    check("to_valid_e7", {30'd0, mem_valid, nub_ackn_o}, 32'b11);
    tick();
    check("to_valid_e8", {31'd0, mem_valid}, 32'd0);
    check("to_ack", {29'd0, nub_oe, nub_ackn_o, 1'b0}, 32'b100);
    check("to_status", {30'd0, nub_tm1n_o, nub_tm0n_o}, 32'b01);
    tick();
    check("to_idle", {29'd0, nub_oe, nub_ackn_o, slave}, 32'b010);
    start(32'h9000_0000, 1'b1);
`ifdef NUBUS_SUPERSLOT_EN
    check("ss_hit", {29'd0, slave, myslot, mem_valid}, 32'b101);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
`else
    check("ss_miss", {30'd0, slave, mem_valid}, 32'd0);
`endif
    start(32'hF900_0200, 1'b1);
    check("rq_valid", {31'd0, mem_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rq_rst_flags", {27'd0, slave, tm1ln, myslot, mem_valid, mem_write}, 32'd0);
    check("rq_rst_addr", mem_addr, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    start(32'hF900_0300, 1'b1);
    check("post_rst_hit", {30'd0, slave, mem_valid}, 32'b11);
    check("post_rst_addr", mem_addr, 32'hF900_0300);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check("post_rst_ack", {28'd0, nub_ackn_o, nub_tm1n_o, nub_tm0n_o, 1'b0}, 32'b0110);
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
